// File: rtl/program_stream_loader_if.sv
// Byte-stream input and CPU instruction-write port of program_stream_loader.
// master is the loader side; slave is the stream source / CPU side.
interface program_stream_loader_if #(
    parameter int INSTR_WIDTH = 16,
    parameter int INDEX_WIDTH = 8
);
    logic                   byte_valid;
    logic [7:0]             byte_data;
    logic                   byte_ready;
    logic                   cpu_write;
    logic [INDEX_WIDTH-1:0] cpu_index;
    logic [INSTR_WIDTH-1:0] cpu_instruction;

    modport master (
        input  byte_valid, byte_data,
        output byte_ready, cpu_write, cpu_index, cpu_instruction
    );

    modport slave (
        output byte_valid, byte_data,
        input  byte_ready, cpu_write, cpu_index, cpu_instruction
    );
endinterface

// File: rtl/program_stream_loader.sv
// Loads a CPU program from a byte stream (16-bit LE word count, then data) into instruction memory.
// Optional trailing XOR checksum byte is enabled by defining PROGRAM_LOADER_CHECKSUM_EN.
module program_stream_loader #(
    parameter int INSTR_WIDTH = 16,
    parameter int INDEX_WIDTH = 8,
    parameter int BASE_INDEX  = 10,
    parameter bit SWAP_BYTES  = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    program_stream_loader_if.master bus,
    output logic                    loading,
    output logic                    done,
    output logic                    error
);
    localparam int BYTES_PER_WORD = INSTR_WIDTH / 8;
    localparam int DEPTH          = (1 << INDEX_WIDTH) - BASE_INDEX;
    localparam int BW             = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    localparam int KW             = (INDEX_WIDTH > 16) ? INDEX_WIDTH + 1 : 17;

    localparam logic [31:0]            DEPTH_W   = 32'(DEPTH);
    localparam logic [INDEX_WIDTH-1:0] BASE      = INDEX_WIDTH'(BASE_INDEX);
    localparam logic [BW-1:0]          LAST_BYTE = BW'(BYTES_PER_WORD - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEN   = 3'd1,
        S_DATA  = 3'd2,
        S_WRITE = 3'd3,
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        S_CSUM  = 3'd4,
`endif
        S_DONE  = 3'd5,
        S_ERROR = 3'd6
    } state_t;

    state_t state, state_next;

    logic [7:0]             len_lo;
    logic [15:0]            n_words;
    logic [BW-1:0]          bcnt;
    logic [KW-1:0]          k;
    logic [INSTR_WIDTH-1:0] asm_reg;
    logic [INSTR_WIDTH-1:0] asm_next;
    logic [INSTR_WIDTH-1:0] byte_ext;
    logic [INDEX_WIDTH-1:0] index_reg;
    logic [INSTR_WIDTH-1:0] instr_reg;
    logic [15:0]            n_rx;
    logic                   xfer;
    logic                   restart;
    logic                   len_done;
    logic                   word_done;
    logic                   last_word;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [7:0]             csum;
`endif

    assign xfer      = bus.byte_valid && bus.byte_ready;
    assign restart   = start && (state == S_IDLE || state == S_DONE || state == S_ERROR);
    assign n_rx      = {bus.byte_data, len_lo};
    assign len_done  = xfer && (state == S_LEN) && (bcnt == BW'(1));
    assign word_done = xfer && (state == S_DATA) && (bcnt == LAST_BYTE);
    assign last_word = (k + KW'(1)) == KW'(n_words);

    // SWAP_BYTES shifts each new byte in at the bottom so the first byte ends up in the MSB;
    // otherwise bytes shift in from the top so the first byte ends up in bits [7:0].
    always_comb begin
        byte_ext = INSTR_WIDTH'(bus.byte_data);
        if (SWAP_BYTES)
            asm_next = (asm_reg << 8) | byte_ext;
        else
            asm_next = (asm_reg >> 8) | (byte_ext << (INSTR_WIDTH - 8));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start)
                    state_next = S_LEN;
            end
            S_LEN: begin
                if (len_done) begin
                    if (n_rx == 16'd0) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                        state_next = S_CSUM;
`else
                        state_next = S_DONE;
`endif
                    end else if ({16'd0, n_rx} > DEPTH_W) begin
                        state_next = S_ERROR;
                    end else begin
                        state_next = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (word_done)
                    state_next = S_WRITE;
            end
            S_WRITE: begin
                if (last_word) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    state_next = S_CSUM;
`else
                    state_next = S_DONE;
`endif
                end else begin
                    state_next = S_DATA;
                end
            end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (xfer)
                    state_next = (bus.byte_data == csum) ? S_DONE : S_ERROR;
            end
`endif
            S_DONE, S_ERROR: begin
                if (start)
                    state_next = S_LEN;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Flag outputs decode the state register only, so byte_ready never depends on byte_valid.
    always_comb begin
        bus.byte_ready = 1'b0;
        bus.cpu_write  = 1'b0;
        loading        = 1'b0;
        done           = 1'b0;
        error          = 1'b0;
        case (state)
            S_LEN, S_DATA: begin
                bus.byte_ready = 1'b1;
                loading        = 1'b1;
            end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            S_CSUM: begin
                bus.byte_ready = 1'b1;
                loading        = 1'b1;
            end
`endif
            S_WRITE: begin
                bus.cpu_write = 1'b1;
                loading       = 1'b1;
            end
            S_DONE:  done  = 1'b1;
            S_ERROR: error = 1'b1;
            default: ;
        endcase
    end

    assign bus.cpu_index       = index_reg;
    assign bus.cpu_instruction = instr_reg;

    // Index and word are captured on the last byte so they hold through WRITE and afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_lo    <= '0;
            n_words   <= '0;
            bcnt      <= '0;
            k         <= '0;
            asm_reg   <= '0;
            index_reg <= '0;
            instr_reg <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            csum      <= '0;
`endif
        end else if (restart) begin
            bcnt <= '0;
            k    <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            csum <= '0;
`endif
        end else begin
            case (state)
                S_LEN: begin
                    if (xfer) begin
                        if (bcnt == BW'(0)) begin
                            len_lo <= bus.byte_data;
                            bcnt   <= BW'(1);
                        end else begin
                            n_words <= n_rx;
                            bcnt    <= '0;
                        end
                    end
                end
                S_DATA: begin
                    if (xfer) begin
                        asm_reg <= asm_next;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                        csum    <= csum ^ bus.byte_data;
`endif
                        if (word_done) begin
                            bcnt      <= '0;
                            index_reg <= BASE + k[INDEX_WIDTH-1:0];
                            instr_reg <= asm_next;
                        end else begin
                            bcnt <= bcnt + BW'(1);
                        end
                    end
                end
                S_WRITE: k <= k + KW'(1);
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_program_stream_loader.sv
// Directed bench for program_stream_loader; two instances (SWAP_BYTES=1 and 0) share one stream.
// Checksum scenarios run when PROGRAM_LOADER_CHECKSUM_EN is defined.
`timescale 1ns/1ps
module tb_program_stream_loader;
    logic       clk        = 1'b0;
    logic       rst_n      = 1'b0;
    logic       start      = 1'b0;
    logic       byte_valid = 1'b0;
    logic [7:0] byte_data  = 8'h00;
    logic       loading1, done1, error1;
    logic       loading0, done0, error0;
    int         tests_run    = 0;
    int         tests_failed = 0;

    logic [7:0]  idx1_q[$];
    logic [15:0] ins1_q[$];
    logic [7:0]  idx0_q[$];
    logic [15:0] ins0_q[$];
    logic [7:0]  stim_q[$];

    program_stream_loader_if #(.INSTR_WIDTH(16), .INDEX_WIDTH(8)) bus1 ();
    program_stream_loader_if #(.INSTR_WIDTH(16), .INDEX_WIDTH(8)) bus0 ();

    assign bus1.byte_valid = byte_valid;
    assign bus1.byte_data  = byte_data;
    assign bus0.byte_valid = byte_valid;
    assign bus0.byte_data  = byte_data;

    program_stream_loader #(
        .INSTR_WIDTH(16), .INDEX_WIDTH(8), .BASE_INDEX(10), .SWAP_BYTES(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bus(bus1),
        .loading(loading1), .done(done1), .error(error1)
    );

    program_stream_loader #(
        .INSTR_WIDTH(16), .INDEX_WIDTH(8), .BASE_INDEX(10), .SWAP_BYTES(1'b0)
    ) dut_swap0 (
        .clk(clk), .rst_n(rst_n), .start(start), .bus(bus0),
        .loading(loading0), .done(done0), .error(error0)
    );

    always #5 clk = ~clk;

    // Every cycle with cpu_write high is logged, so a repeated strobe shows up as an extra entry.
    always @(negedge clk) begin
        if (bus1.cpu_write === 1'b1) begin
            idx1_q.push_back(bus1.cpu_index);
            ins1_q.push_back(bus1.cpu_instruction);
        end
        if (bus0.cpu_write === 1'b1) begin
            idx0_q.push_back(bus0.cpu_index);
            ins0_q.push_back(bus0.cpu_instruction);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        idx1_q.delete();
        ins1_q.delete();
        idx0_q.delete();
        ins0_q.delete();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gappy);
        bit ok = 1'b0;
        if (gappy)
            repeat ($urandom_range(0, 2)) tick();
        byte_valid = 1'b1;
        byte_data  = b;
        for (int i = 0; i < 50 && !ok; i++) begin
            ok = (bus1.byte_ready === 1'b1);
            tick();
        end
        byte_valid = 1'b0;
        if (!ok) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL byte_timeout: byte %02h not accepted, ready=%b required 1", b, bus1.byte_ready);
        end
    endtask

    task automatic send_stim(input bit gappy);
        foreach (stim_q[i]) send_byte(stim_q[i], gappy);
    endtask

    task automatic finish_stim();
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        logic [7:0] x = 8'h00;
        for (int i = 2; i < stim_q.size(); i++) x ^= stim_q[i];
        stim_q.push_back(x);
`endif
    endtask

    task automatic wait_end();
        for (int i = 0; i < 20 && !(done1 || error1); i++) tick();
        if (!(done1 || error1)) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL end_timeout: done=%b error=%b required one of them 1", done1, error1);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        tests_run++;
        if ({bus1.byte_ready, bus1.cpu_write, bus1.cpu_index, bus1.cpu_instruction, loading1, done1, error1} !== 29'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_held: outputs=%h required 0",
                {bus1.byte_ready, bus1.cpu_write, bus1.cpu_index, bus1.cpu_instruction, loading1, done1, error1});
        end
        rst_n = 1'b1;
        repeat (2) tick();
        tests_run++;
        if ({bus1.byte_ready, bus1.cpu_write, loading1, done1, error1} !== 5'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_idle: flags=%b required 00000",
                {bus1.byte_ready, bus1.cpu_write, loading1, done1, error1});
        end
    endtask

    task automatic test_basic(input bit gappy);
        logic [15:0] exp1[3] = '{16'h2021, 16'h0022, 16'h0023};
        logic [15:0] exp0[3] = '{16'h2120, 16'h2200, 16'h2300};
        clear_log();
        pulse_start();
        tests_run++;
        if ({loading1, bus1.byte_ready} !== 2'b11) begin
            tests_failed++;
            $display("[TB] FAIL start_len: loading,ready=%b required 11", {loading1, bus1.byte_ready});
        end
        stim_q = '{8'h03, 8'h00, 8'h20, 8'h21, 8'h00, 8'h22, 8'h00, 8'h23};
        finish_stim();
        send_stim(gappy);
        wait_end();
        tests_run++;
        if (idx1_q.size() != 3 || idx0_q.size() != 3) begin
            tests_failed++;
            $display("[TB] FAIL basic_count gappy=%0d: writes=%0d/%0d required 3/3", gappy, idx1_q.size(), idx0_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                tests_run++;
                if (idx1_q[i] !== 8'(10 + i) || ins1_q[i] !== exp1[i]) begin
                    tests_failed++;
                    $display("[TB] FAIL basic_swap1_w%0d: got (%0d,%h) required (%0d,%h)", i, idx1_q[i], ins1_q[i], 10 + i, exp1[i]);
                end
                tests_run++;
                if (idx0_q[i] !== 8'(10 + i) || ins0_q[i] !== exp0[i]) begin
                    tests_failed++;
                    $display("[TB] FAIL basic_swap0_w%0d: got (%0d,%h) required (%0d,%h)", i, idx0_q[i], ins0_q[i], 10 + i, exp0[i]);
                end
            end
        end
        tests_run++;
        if ({done1, loading1, error1, done0} !== 4'b1001) begin
            tests_failed++;
            $display("[TB] FAIL basic_flags: done,loading,error,done0=%b required 1001", {done1, loading1, error1, done0});
        end
`ifndef PROGRAM_LOADER_CHECKSUM_EN
        byte_valid = 1'b1;
        byte_data  = 8'h5A;
        repeat (3) tick();
        byte_valid = 1'b0;
        tests_run++;
        if ({bus1.byte_ready, done1} !== 2'b01 || idx1_q.size() != 3) begin
            tests_failed++;
            $display("[TB] FAIL done_no_accept: ready,done=%b writes=%0d required 01 and 3", {bus1.byte_ready, done1}, idx1_q.size());
        end
`endif
    endtask

    task automatic test_latency();
        clear_log();
        pulse_start();
        send_byte(8'h01, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h12, 1'b0);
        tests_run++;
        if (bus1.cpu_write !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL latency_early: cpu_write=%b required 0", bus1.cpu_write);
        end
        send_byte(8'h34, 1'b0);
        tests_run++;
        if ({bus1.cpu_write, bus1.cpu_index, bus1.cpu_instruction} !== {1'b1, 8'd10, 16'h1234}) begin
            tests_failed++;
            $display("[TB] FAIL latency_strobe: write=%b idx=%0d ins=%h required 1,10,1234",
                bus1.cpu_write, bus1.cpu_index, bus1.cpu_instruction);
        end
        tick();
        tests_run++;
        if ({bus1.cpu_write, bus1.cpu_index, bus1.cpu_instruction} !== {1'b0, 8'd10, 16'h1234}) begin
            tests_failed++;
            $display("[TB] FAIL latency_hold: write=%b idx=%0d ins=%h required 0,10,1234",
                bus1.cpu_write, bus1.cpu_index, bus1.cpu_instruction);
        end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        send_byte(8'h26, 1'b0);
`endif
        wait_end();
        tests_run++;
        if (done1 !== 1'b1 || idx1_q.size() != 1) begin
            tests_failed++;
            $display("[TB] FAIL latency_done: done=%b writes=%0d required 1 and 1", done1, idx1_q.size());
        end
    endtask

    task automatic test_oversize();
        clear_log();
        pulse_start();
        send_byte(8'hF7, 1'b0);
        send_byte(8'h00, 1'b0);
        tests_run++;
        if ({error1, done1, loading1, bus1.byte_ready} !== 4'b1000) begin
            tests_failed++;
            $display("[TB] FAIL oversize_flags: error,done,loading,ready=%b required 1000",
                {error1, done1, loading1, bus1.byte_ready});
        end
        repeat (4) tick();
        tests_run++;
        if (idx1_q.size() != 0 || error1 !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL oversize_writes: writes=%0d error=%b required 0 and 1", idx1_q.size(), error1);
        end
    endtask

    task automatic test_full_depth();
        int bad = 0;
        clear_log();
        pulse_start();
        stim_q = '{8'hF6, 8'h00};
        for (int i = 0; i < 246; i++) begin
            stim_q.push_back(8'(i));
            stim_q.push_back(8'hC3 ^ 8'(i));
        end
        finish_stim();
        send_stim(1'b0);
        wait_end();
        tests_run++;
        if (idx1_q.size() != 246 || done1 !== 1'b1 || error1 !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL depth_count: writes=%0d done=%b error=%b required 246,1,0", idx1_q.size(), done1, error1);
        end else begin
            for (int i = 0; i < 246; i++)
                if (idx1_q[i] !== 8'(10 + i) || ins1_q[i] !== {8'(i), 8'hC3 ^ 8'(i)}) bad++;
            tests_run++;
            if (bad != 0) begin
                tests_failed++;
                $display("[TB] FAIL depth_seq: %0d bad writes required 0", bad);
            end
            tests_run++;
            if (idx1_q[245] !== 8'd255 || ins1_q[245] !== 16'hF536 || ins0_q[245] !== 16'h36F5) begin
                tests_failed++;
                $display("[TB] FAIL depth_last: got (%0d,%h,%h) required (255,f536,36f5)", idx1_q[245], ins1_q[245], ins0_q[245]);
            end
        end
    endtask

    task automatic test_reset_mid_load();
        clear_log();
        pulse_start();
        stim_q = '{8'h03, 8'h00, 8'h20, 8'h21, 8'h00, 8'h22, 8'h00, 8'h23};
        for (int i = 0; i < 6; i++) send_byte(stim_q[i], 1'b0);
        tick();
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({bus1.byte_ready, bus1.cpu_write, bus1.cpu_index, bus1.cpu_instruction, loading1, done1, error1} !== 29'd0
            || idx1_q.size() != 2) begin
            tests_failed++;
            $display("[TB] FAIL midreset_outputs: outputs=%h writes=%0d required 0 and 2",
                {bus1.byte_ready, bus1.cpu_write, bus1.cpu_index, bus1.cpu_instruction, loading1, done1, error1}, idx1_q.size());
        end
        tick();
        rst_n = 1'b1;
        tick();
        clear_log();
        pulse_start();
        stim_q = '{8'h01, 8'h00, 8'hAB, 8'hCD};
        finish_stim();
        send_stim(1'b0);
        wait_end();
        tests_run++;
        if (idx1_q.size() != 1 || done1 !== 1'b1 || error1 !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL midreset_reload: writes=%0d done=%b error=%b required 1,1,0", idx1_q.size(), done1, error1);
        end else begin
            tests_run++;
            if (idx1_q[0] !== 8'd10 || ins1_q[0] !== 16'hABCD) begin
                tests_failed++;
                $display("[TB] FAIL midreset_word: got (%0d,%h) required (10,abcd)", idx1_q[0], ins1_q[0]);
            end
        end
    endtask

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    task automatic test_checksum_bad();
        clear_log();
        pulse_start();
        stim_q = '{8'h01, 8'h00, 8'hAB, 8'hCD, 8'h67};
        send_stim(1'b0);
        wait_end();
        tests_run++;
        if ({error1, done1} !== 2'b10 || idx1_q.size() != 1) begin
            tests_failed++;
            $display("[TB] FAIL csum_bad: error,done=%b writes=%0d required 10 and 1", {error1, done1}, idx1_q.size());
        end else begin
            tests_run++;
            if (idx1_q[0] !== 8'd10 || ins1_q[0] !== 16'hABCD) begin
                tests_failed++;
                $display("[TB] FAIL csum_bad_word: got (%0d,%h) required (10,abcd)", idx1_q[0], ins1_q[0]);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic(1'b0);
        test_latency();
        test_basic(1'b1);
        test_oversize();
        test_full_depth();
        test_reset_mid_load();
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        test_checksum_bad();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
